// File: rtl/pll_gear_ctrl.sv
// PLL loop-filter gear sequencer: precharges (clears) the filter, then steps tau
// gears as phase error settles, declares lock and re-acquires on loss of lock.
module pll_gear_ctrl #(
    parameter int ERR_W     = 12,
    parameter int THRESH    = 16,
    parameter int DWELL     = 64,
    parameter int NUM_GEARS = 4,
    parameter int PRE_CYC   = 8,
    parameter int UNLOCK_N  = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         err_valid,
    input  logic signed [ERR_W-1:0]      err,
    output logic [$clog2(NUM_GEARS)-1:0] gear,
    output logic                         filter_rst,
    output logic                         busy,
    output logic                         locked,
    output logic                         fail,
    output logic [3:0]                   relock_cnt
);

    localparam int GEAR_W = $clog2(NUM_GEARS);
    localparam int PRE_W  = $clog2(PRE_CYC + 1);
    localparam int DW_W   = $clog2(DWELL + 1);
    localparam int MISS_W = $clog2(UNLOCK_N + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [GEAR_W-1:0]       GEAR_MAX  = GEAR_W'(NUM_GEARS - 1);
    localparam logic [PRE_W-1:0]        PRE_LOAD  = PRE_W'(PRE_CYC - 1);
    localparam logic [DW_W-1:0]         DWELL_M1  = DW_W'(DWELL - 1);
    localparam logic [MISS_W-1:0]       MISS_M1   = MISS_W'(UNLOCK_N - 1);
    localparam logic [TMO_W-1:0]        TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]        THRESH_U  = ERR_W'(THRESH);
    localparam logic signed [ERR_W-1:0] ERR_MIN   = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0]        ERR_MAX_U = {1'b0, {(ERR_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACQ,
        S_LOCK,
        S_FAIL
    } state_t;

    // Magnitude with the most negative code clamped so it cannot wrap to itself
    function automatic logic [ERR_W-1:0] abs_sat(input logic signed [ERR_W-1:0] v);
        logic [ERR_W-1:0] mag;
        if (v == ERR_MIN)
            mag = ERR_MAX_U;
        else if (v[ERR_W-1])
            mag = $unsigned(-v);
        else
            mag = $unsigned(v);
        return mag;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [GEAR_W-1:0]   r_gear, w_gear_nxt;
    logic [PRE_W-1:0]    r_pre, w_pre_nxt;
    logic [DW_W-1:0]     r_dwell, w_dwell_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic [3:0]          r_relock, w_relock_nxt;
    logic                r_fail, w_fail_nxt;
    logic                r_frst, r_busy, r_locked;
    logic                w_in_win;

    assign w_in_win = (abs_sat(err) <= THRESH_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gear_nxt   = r_gear;
        w_pre_nxt    = r_pre;
        w_dwell_nxt  = r_dwell;
        w_miss_nxt   = r_miss;
        w_tmo_nxt    = r_tmo;
        w_relock_nxt = r_relock;
        w_fail_nxt   = r_fail;

        // start wins over everything and swallows any same-cycle sample
        if (start) begin
            w_state_nxt  = S_PRE;
            w_pre_nxt    = PRE_LOAD;
            w_gear_nxt   = '0;
            w_dwell_nxt  = '0;
            w_miss_nxt   = '0;
            w_tmo_nxt    = '0;
            w_relock_nxt = '0;
            w_fail_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_PRE: begin
                    if (r_pre == '0) begin
                        w_state_nxt = S_ACQ;
                        w_tmo_nxt   = '0;
                        w_dwell_nxt = '0;
                    end else begin
                        w_pre_nxt = r_pre - PRE_W'(1);
                    end
                end
                S_ACQ: begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                    if (err_valid)
                        w_dwell_nxt = w_in_win ? r_dwell + DW_W'(1) : '0;
                    if (err_valid && w_in_win && (r_dwell == DWELL_M1)) begin
                        w_dwell_nxt = '0;
                        if (r_gear == GEAR_MAX) begin
                            w_state_nxt = S_LOCK;
                            w_miss_nxt  = '0;
                        end else begin
                            w_gear_nxt = r_gear + GEAR_W'(1);
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        w_state_nxt = S_FAIL;
                        w_gear_nxt  = '0;
                        w_dwell_nxt = '0;
                        w_fail_nxt  = 1'b1;
                    end
                end
                S_LOCK: begin
                    if (err_valid) begin
                        if (w_in_win) begin
                            w_miss_nxt = '0;
                        end else if (r_miss == MISS_M1) begin
                            w_state_nxt  = S_ACQ;
                            w_gear_nxt   = '0;
                            w_dwell_nxt  = '0;
                            w_miss_nxt   = '0;
                            w_tmo_nxt    = '0;
                            w_relock_nxt = (r_relock == 4'hF) ? r_relock : r_relock + 4'd1;
                        end else begin
                            w_miss_nxt = r_miss + MISS_W'(1);
                        end
                    end
                end
                S_FAIL: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gear   <= '0;
            r_pre    <= '0;
            r_dwell  <= '0;
            r_miss   <= '0;
            r_tmo    <= '0;
            r_relock <= '0;
            r_fail   <= 1'b0;
            r_frst   <= 1'b0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_gear   <= w_gear_nxt;
            r_pre    <= w_pre_nxt;
            r_dwell  <= w_dwell_nxt;
            r_miss   <= w_miss_nxt;
            r_tmo    <= w_tmo_nxt;
            r_relock <= w_relock_nxt;
            r_fail   <= w_fail_nxt;
            r_frst   <= (w_state_nxt == S_PRE);
            r_busy   <= (w_state_nxt == S_PRE) || (w_state_nxt == S_ACQ) || (w_state_nxt == S_LOCK);
            r_locked <= (w_state_nxt == S_LOCK);
        end
    end

    assign gear       = r_gear;
    assign filter_rst = r_frst;
    assign busy       = r_busy;
    assign locked     = r_locked;
    assign fail       = r_fail;
    assign relock_cnt = r_relock;

endmodule

// File: tb/tb_pll_gear_ctrl.sv
// Bench for pll_gear_ctrl: table of stimulus phases with hand-derived end-of-phase
// outputs, queued when driven and compared after the edge, plus async-reset sequences.
module tb_pll_gear_ctrl;

    localparam int ERR_W = 12;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    start = 1'b0;
    logic                    err_valid = 1'b0;
    logic signed [ERR_W-1:0] err = '0;
    logic [1:0]              gear;
    logic                    filter_rst, busy, locked, fail;
    logic [3:0]              relock_cnt;

    always #5 clk = ~clk;

    pll_gear_ctrl #(
        .ERR_W(12), .THRESH(16), .DWELL(64), .NUM_GEARS(4),
        .PRE_CYC(8), .UNLOCK_N(4), .TIMEOUT(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .err_valid(err_valid), .err(err),
        .gear(gear), .filter_rst(filter_rst), .busy(busy), .locked(locked),
        .fail(fail), .relock_cnt(relock_cnt)
    );

    typedef struct {
        logic                    st;
        logic                    vld;
        logic signed [ERR_W-1:0] e;
        int                      n;
        logic [9:0]              exp;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         errors = 0;
    int         checks = 0;

    function automatic logic [9:0] pk(int g, bit fr, bit b, bit l, bit f, int r);
        logic [1:0] g2;
        logic [3:0] r4;
        g2 = g[1:0];
        r4 = r[3:0];
        return {g2, fr, b, l, f, r4};
    endfunction

    function automatic void add(bit st, bit vld, int e, int n, logic [9:0] ex);
        vec_t v;
        v.st  = st;
        v.vld = vld;
        v.e   = ERR_W'(e);
        v.n   = n;
        v.exp = ex;
        tbl.push_back(v);
    endfunction

    function automatic logic [9:0] outs();
        return {gear, filter_rst, busy, locked, fail, relock_cnt};
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got gear=%0d frst=%b busy=%b locked=%b fail=%b relock=%0d, expected gear=%0d frst=%b busy=%b locked=%b fail=%b relock=%0d",
                     nm, act[9:8], act[7], act[6], act[5], act[4], act[3:0],
                     ex[9:8], ex[7], ex[6], ex[5], ex[4], ex[3:0]);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [9:0] ex;
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            start     = v.st;
            err_valid = v.vld;
            err       = v.e;
            if (k == v.n - 1) sb.push_back(v.exp);
            @(posedge clk);
            #1;
            if (k == v.n - 1) begin
                ex = sb.pop_front();
                check($sformatf("vec%0d", idx), outs(), ex);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        err_valid = 1'b1;
        err       = '0;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", outs(), pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire from scratch with err=0
        add(0, 0, 0,    2,   pk(0, 0, 0, 0, 0, 0));
        add(1, 1, 0,    1,   pk(0, 1, 1, 0, 0, 0));
        add(0, 1, 0,    7,   pk(0, 1, 1, 0, 0, 0));
        add(0, 1, 0,    1,   pk(0, 0, 1, 0, 0, 0));
        add(0, 1, 0,    63,  pk(0, 0, 1, 0, 0, 0));
        add(0, 1, 0,    1,   pk(1, 0, 1, 0, 0, 0));
        add(0, 1, 0,    64,  pk(2, 0, 1, 0, 0, 0));
        add(0, 1, 0,    64,  pk(3, 0, 1, 0, 0, 0));
        add(0, 1, 0,    63,  pk(3, 0, 1, 0, 0, 0));
        add(0, 1, 0,    1,   pk(3, 0, 1, 1, 0, 0));
        // Miss bursts in LOCKED, with a gap
        add(0, 1, 100,  3,   pk(3, 0, 1, 1, 0, 0));
        add(0, 1, 0,    1,   pk(3, 0, 1, 1, 0, 0));
        add(0, 1, 100,  3,   pk(3, 0, 1, 1, 0, 0));
        add(0, 0, 100,  5,   pk(3, 0, 1, 1, 0, 0));
        add(0, 1, 100,  1,   pk(0, 0, 1, 0, 0, 1));
        // Window edges and dwell clearing
        add(0, 1, -16,  63,  pk(0, 0, 1, 0, 0, 1));
        add(0, 1, -16,  1,   pk(1, 0, 1, 0, 0, 1));
        add(0, 1, 16,   63,  pk(1, 0, 1, 0, 0, 1));
        add(0, 1, 17,   1,   pk(1, 0, 1, 0, 0, 1));
        add(0, 1, 16,   63,  pk(1, 0, 1, 0, 0, 1));
        add(0, 1, -16,  1,   pk(2, 0, 1, 0, 0, 1));
        add(0, 1, 0,    32,  pk(2, 0, 1, 0, 0, 1));
        add(0, 0, 999,  10,  pk(2, 0, 1, 0, 0, 1));
        add(0, 1, 0,    31,  pk(2, 0, 1, 0, 0, 1));
        add(0, 1, 0,    1,   pk(3, 0, 1, 0, 0, 1));
        add(0, 1, 500,  5,   pk(3, 0, 1, 0, 0, 1));
        add(0, 1, 0,    64,  pk(3, 0, 1, 1, 0, 1));
        add(0, 1, 100,  4,   pk(0, 0, 1, 0, 0, 2));
        add(0, 1, 0,    256, pk(3, 0, 1, 1, 0, 2));
        add(0, 1, -100, 4,   pk(0, 0, 1, 0, 0, 3));
        add(0, 1, 0,    256, pk(3, 0, 1, 1, 0, 3));
        // Restart while LOCKED, same-cycle sample discarded
        add(1, 1, 100,  1,   pk(0, 1, 1, 0, 0, 0));
        add(0, 1, 0,    7,   pk(0, 1, 1, 0, 0, 0));
        add(0, 1, 0,    1,   pk(0, 0, 1, 0, 0, 0));
        // Most negative error never settles -> timeout
        add(0, 1, -2048, 4095, pk(0, 0, 1, 0, 0, 0));
        add(0, 1, -2048, 1,    pk(0, 0, 0, 0, 1, 0));
        add(0, 1, 0,    5,   pk(0, 0, 0, 0, 1, 0));
        add(1, 1, 0,    1,   pk(0, 1, 1, 0, 0, 0));
        add(0, 1, 0,    7,   pk(0, 1, 1, 0, 0, 0));
        add(0, 1, 0,    1,   pk(0, 0, 1, 0, 0, 0));
        // Relock counter saturation
        for (int i = 0; i < 16; i++) begin
            add(0, 1, 0,    256, pk(3, 0, 1, 1, 0, (i > 15) ? 15 : i));
            add(0, 1, 2047, 4,   pk(0, 0, 1, 0, 0, (i + 1 > 15) ? 15 : i + 1));
        end
        add(0, 0, 0, 1, pk(0, 0, 1, 0, 0, 15));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Async reset mid-PRECHARGE
        pulse_start();
        repeat (2) @(posedge clk);
        #1 check("pre_mid", outs(), pk(0, 1, 1, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 check("arst_pre", outs(), pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_after_arst", outs(), pk(0, 0, 0, 0, 0, 0));

        // Async reset mid-LOCKED
        pulse_start();
        repeat (264) @(posedge clk);
        #1 check("lock_again", outs(), pk(3, 0, 1, 1, 0, 0));
        #2 rst_n = 1'b0;
        #1 check("arst_lock", outs(), pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        err_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_after_arst2", outs(), pk(0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
